// File: rtl/timer_pkg.sv
// Shared encodings for the programmable timer: FSM states and the dir/mode input codes.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

    localparam logic DIR_UP       = 1'b0;
    localparam logic DIR_DOWN     = 1'b1;
    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/timer_prescaler.sv
// Tick divider: while run is high, raises tick once every prescale+1 cycles; the phase is held while run is low.
module timer_prescaler #(
    parameter int PS_W = 4
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            run,
    input  logic            sync_clr,
    input  logic [PS_W-1:0] prescale,
    output logic            tick
);

    logic [PS_W-1:0] cnt;

    // A compare of >= lets a prescale lowered below the current phase take effect on the next cycle.
    assign tick = run && (cnt >= prescale);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt <= '0;
        end else if (sync_clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= tick ? '0 : cnt + PS_W'(1);
        end
    end

endmodule

// File: rtl/prog_timer.sv
// Programmable up/down timer with prescaler, one-shot or auto-reload expiry, and a registered done pulse.
module prog_timer
    import timer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int PS_W  = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic             mode,
    input  logic [PS_W-1:0]  prescale,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done,
    output logic             running
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] reload;
    logic [WIDTH-1:0] terminal;
    logic             run;
    logic             tick;

    assign terminal = (dir == DIR_DOWN) ? '0 : '1;
    assign tc       = (count == terminal);

    // Gating with en both ignores a coincident tick and freezes the prescaler phase on pause.
    assign run = (state == ST_RUN) && en;

    timer_prescaler #(
        .PS_W(PS_W)
    ) u_prescaler (
        .clk     (clk),
        .clr     (clr),
        .run     (run),
        .sync_clr(load),
        .prescale(prescale),
        .tick    (tick)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so no latch is inferred.
    always_comb begin
        state_next = state;
        if (load) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en) state_next = ST_RUN;
                end
                ST_RUN: begin
                    if (!en) begin
                        state_next = ST_IDLE;
                    end else if (tick && tc && (mode == MODE_ONESHOT)) begin
                        state_next = ST_EXPIRED;
                    end
                end
                ST_EXPIRED: state_next = ST_EXPIRED;
                default:    state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        running = (state == ST_RUN);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count  <= '0;
            reload <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                count  <= load_val;
                reload <= load_val;
            end else if (tick) begin
                if (!tc) begin
                    count <= (dir == DIR_DOWN) ? count - WIDTH'(1) : count + WIDTH'(1);
                end else begin
                    // One-shot holds count at terminal; the FSM moves to EXPIRED.
                    done <= 1'b1;
                    if (mode == MODE_RELOAD) count <= reload;
                end
            end
        end
    end

endmodule

// File: tb/tb_prog_timer.sv
// Self-checking bench for prog_timer: directed scenarios with literal expectations, then randomized traffic vs a behavioural model.
module tb_prog_timer;
    import timer_pkg::*;

    localparam int WIDTH = 4;
    localparam int PS_W  = 4;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             clr;
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             dir;
    logic             mode;
    logic [PS_W-1:0]  prescale;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             done;
    logic             running;

    int n_checks = 0;
    int n_fail   = 0;

    prog_timer #(
        .WIDTH(WIDTH),
        .PS_W (PS_W)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .en      (en),
        .load    (load),
        .load_val(load_val),
        .dir     (dir),
        .mode    (mode),
        .prescale(prescale),
        .count   (count),
        .tc      (tc),
        .done    (done),
        .running (running)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Behavioural model: counts run cycles since the last tick and steps the count with modular arithmetic.
    typedef enum {M_IDLE, M_RUN, M_EXP} mstate_t;
    mstate_t m_state      = M_IDLE;
    int      m_count      = 0;
    int      m_reload     = 0;
    int      m_run_cycles = 0;
    bit      m_done       = 1'b0;

    function automatic int terminal_of(input logic d);
        return d ? 0 : MAXV;
    endfunction

    initial forever begin
        @(posedge clk or posedge clr);
        if (clr) begin
            m_state = M_IDLE; m_count = 0; m_reload = 0; m_run_cycles = 0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (load) begin
                m_count = int'(load_val); m_reload = int'(load_val);
                m_run_cycles = 0; m_state = M_IDLE;
            end else if (m_state == M_IDLE) begin
                if (en) m_state = M_RUN;
            end else if (m_state == M_RUN) begin
                if (!en) begin
                    m_state = M_IDLE;
                end else if (m_run_cycles >= int'(prescale)) begin
                    m_run_cycles = 0;
                    if (m_count != terminal_of(dir)) begin
                        m_count = (m_count + (dir ? MAXV : 1)) % (MAXV + 1);
                    end else begin
                        m_done = 1'b1;
                        if (mode) m_count = m_reload;
                        else      m_state = M_EXP;
                    end
                end else begin
                    m_run_cycles++;
                end
            end
        end
    end

    // Per-cycle comparison, sampled shortly after each rising edge.
    initial forever begin
        @(posedge clk);
        #2;
        check("cyc_count",   count,   m_count);
        check("cyc_tc",      tc,      (m_count == terminal_of(dir)));
        check("cyc_done",    done,    m_done);
        check("cyc_running", running, (m_state == M_RUN));
    end

    task automatic do_load(input int v, input logic d, input logic m, input int ps);
        logic [31:0] vv;
        logic [31:0] pp;
        vv = v; pp = ps;
        load = 1'b1; load_val = vv[WIDTH-1:0]; dir = d; mode = m;
        prescale = pp[PS_W-1:0]; en = 1'b0;
        cyc(1);
        load = 1'b0;
    endtask

    int exp_seq [12] = '{4, 3, 2, 1, 0, 5, 4, 3, 2, 1, 0, 5};
    int n_done;

    initial begin
        clr = 1'b1; en = 1'b0; load = 1'b0; load_val = '0; dir = 1'b0; mode = 1'b0; prescale = '0;
        cyc(2);
        check("rst_count",   count,   0);
        check("rst_running", running, 0);
        check("rst_done",    done,    0);
        check("rst_tc_up",   tc,      0);
        dir = 1'b1;
        #1;
        check("rst_tc_down", tc, 1);
        dir = 1'b0;
        clr = 1'b0;
        cyc(1);

        // One-shot up count 0..15, then EXPIRED
        do_load(0, 1'b0, 1'b0, 0);
        en = 1'b1;
        cyc(1);
        check("os_enter_running", running, 1);
        check("os_enter_count",   count,   0);
        cyc(15);
        check("os_count15", count,   15);
        check("os_tc15",    tc,      1);
        check("os_nodone",  done,    0);
        check("model_os_count15", m_count, 15);
        cyc(1);
        check("os_done",      done,    1);
        check("os_stopped",   running, 0);
        check("os_held",      count,   15);
        cyc(1);
        check("os_done_once", done,    0);
        check("os_held2",     count,   15);
        check("os_expired",   running, 0);

        // Auto-reload down count from 5
        do_load(5, 1'b1, 1'b1, 0);
        en = 1'b1;
        cyc(1);
        check("ar_start", count, 5);
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            check("ar_seq", count, exp_seq[i]);
            if (done) n_done++;
        end
        check("ar_done_pulses", n_done, 2);
        check("ar_running", running, 1);

        // Prescale 3 with a 5-cycle pause
        do_load(0, 1'b0, 1'b0, 3);
        en = 1'b1;
        cyc(1);
        cyc(3);
        check("ps_hold", count, 0);
        cyc(1);
        check("ps_tick1", count, 1);
        cyc(3);
        check("ps_hold2", count, 1);
        cyc(1);
        check("ps_tick2", count, 2);
        cyc(2);
        en = 1'b0;
        cyc(5);
        check("ps_paused_count",   count,   2);
        check("ps_paused_running", running, 0);
        en = 1'b1;
        cyc(2);
        check("ps_resume_hold", count, 2);
        cyc(1);
        check("ps_resume_tick", count, 3);
        check("model_ps_resume", m_count, 3);

        // Direction flip at 7
        do_load(7, 1'b0, 1'b0, 0);
        en = 1'b1;
        cyc(1);
        check("dir_at7", count, 7);
        dir = 1'b1;
        cyc(1);
        check("dir_flip", count, 6);

        // Load coincident with a terminal tick
        do_load(14, 1'b0, 1'b0, 0);
        en = 1'b1;
        cyc(2);
        check("ld_pre", count, 15);
        load = 1'b1; load_val = 4'd9;
        cyc(1);
        load = 1'b0;
        check("ld_count",   count,   9);
        check("ld_idle",    running, 0);
        check("ld_no_done", done,    0);
        en = 1'b0;
        cyc(1);
        check("ld_no_done2", done, 0);

        // Async clear during a done pulse
        do_load(14, 1'b0, 1'b1, 0);
        en = 1'b1;
        cyc(3);
        check("clr_pre_done", done, 1);
        #2 clr = 1'b1;
        #1;
        check("clr_count",   count,   0);
        check("clr_running", running, 0);
        check("clr_done",    done,    0);
        check("clr_tc",      tc,      0);
        cyc(1);
        clr = 1'b0;
        cyc(1);
        check("clr_resume_running", running, 1);
        check("clr_resume_count",   count,   0);
        cyc(1);
        check("clr_resume_step",    count,   1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            load = ($urandom_range(0, 99) < 4);
            if (load) begin
                load_val = WIDTH'($urandom);
                prescale = PS_W'($urandom_range(0, 3));
            end
            en = ($urandom_range(0, 99) < 85);
            if ($urandom_range(0, 99) < 5) dir = ~dir;
            if ($urandom_range(0, 99) < 5) mode = ~mode;
            if ($urandom_range(0, 999) < 5) begin
                #1 clr = 1'b1;
                #2 clr = 1'b0;
            end
            cyc(1);
        end
        load = 1'b0;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
